// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, packs it into 32-bit
// words written to instruction memory from address 0, and releases cpu_hold on a verified image.
module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]   MAX_WORDS = 17'(1) << ADDR_WIDTH;
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR
  } stateT;

  stateT         state, nextState;
  logic [7:0]    lenHi;
  logic [15:0]   wordsTotal;
  logic [15:0]   lenWord;
  logic [31:0]   wordReg;
  logic [1:0]    byteCnt;
  logic [7:0]    checksum;
  logic [TW-1:0] toCnt;
  logic          accept;
  logic          timedOut;
  logic          restart;
  logic          lastWord;

  always_comb begin
    rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHECK);
    accept   = rx_valid && rx_ready;
    lenWord  = {lenHi, rx_data};
    // The increment that would reach TIMEOUT_CYCLES-1 is taken as the error transition.
    timedOut = rx_ready && !accept && (toCnt == TO_LIMIT);
    restart  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    lastWord = ({1'b0, word_count} + 17'd1) >= {1'b0, wordsTotal};
  end

  always_comb begin
    nextState  = state;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    case (state)
      IDLE:   if (start) nextState = LEN_HI;
      LEN_HI: begin
        if (timedOut)    nextState = ERROR;
        else if (accept) nextState = LEN_LO;
      end
      LEN_LO: begin
        if (timedOut) nextState = ERROR;
        else if (accept) begin
          if ({1'b0, lenWord} > MAX_WORDS) nextState = ERROR;
          else if (lenWord == 16'd0)       nextState = CHECK;
          else                             nextState = DATA;
        end
      end
      DATA: begin
        if (timedOut)                         nextState = ERROR;
        else if (accept && byteCnt == 2'd3)   nextState = WRITE;
      end
      WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = word_count[ADDR_WIDTH-1:0];
        imem_wdata = wordReg;
        nextState  = lastWord ? CHECK : DATA;
      end
      CHECK: begin
        if (timedOut)    nextState = ERROR;
        else if (accept) nextState = (rx_data == checksum) ? DONE : ERROR;
      end
      DONE:    if (start) nextState = LEN_HI;
      ERROR:   if (start) nextState = LEN_HI;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lenHi      <= '0;
      wordsTotal <= '0;
      wordReg    <= '0;
      byteCnt    <= '0;
      checksum   <= '0;
      toCnt      <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      // Status flags follow the state one cycle late; a restart drops them at the same edge.
      done     <= (state == DONE) && !start;
      error    <= (state == ERROR) && !start;
      cpu_hold <= !((state == DONE) && !start);

      if (restart) begin
        word_count <= '0;
        checksum   <= '0;
        byteCnt    <= '0;
        toCnt      <= '0;
      end else if (accept) begin
        toCnt <= '0;
      end else if (rx_ready) begin
        toCnt <= toCnt + TW'(1);
      end

      if (accept) begin
        case (state)
          LEN_HI: lenHi <= rx_data;
          LEN_LO: wordsTotal <= lenWord;
          DATA: begin
            wordReg  <= {wordReg[23:0], rx_data};
            checksum <= checksum ^ rx_data;
            byteCnt  <= byteCnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (state == WRITE) word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random images and gaps against a stream-level model.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] img[$];
  logic [7:0]  wrAddr[$];
  logic [31:0] wrData[$];

  program_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  // Instruction memory stand-in: log every write in order.
  always @(posedge clock) begin
    if (imem_we) begin
      wrAddr.push_back(imem_addr);
      wrData.push_back(imem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int waited;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!rx_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL sendByte: rx_ready never rose, got %0b required 1", rx_ready);
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  function automatic int pickGap(input int gapMax);
    return (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 0));
  endfunction

  // Stream model: big-endian length, words MSB first, then XOR of all data bytes.
  task automatic sendImage(input int gapMax, input bit badCk);
    logic [7:0] ck;
    logic [7:0] b;
    int n;
    n  = img.size();
    ck = 8'h00;
    sendByte(8'((n >> 8) & 255), pickGap(gapMax));
    sendByte(8'(n & 255), pickGap(gapMax));
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b  = 8'((img[i] >> (8 * k)) & 32'hFF);
        ck = ck ^ b;
        sendByte(b, pickGap(gapMax));
      end
    end
    sendByte(badCk ? (ck ^ 8'h01) : ck, pickGap(gapMax));
  endtask

  task automatic waitEnd(output int cyc);
    cyc = 0;
    while (!(done || error) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %0b required 1", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b required 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b required 0", error); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %0b required 0", rx_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we got %0b required 0", imem_we); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_word_count got %0d required 0", word_count); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL idle_rx_ready got %0b required 0", rx_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL idle_cpu_hold got %0b required 1", cpu_hold); end
  endtask

  task automatic test_basic(input int gapMax, input string tag);
    int base, cyc;
    img  = '{32'h11223344, 32'hAABBCCDD};
    base = wrAddr.size();
    pulseStart();
    sendImage(gapMax, 1'b0);
    waitEnd(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done got %0b required 1", tag, done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL %s_error got %0b required 0", tag, error); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL %s_cpu_hold got %0b required 0", tag, cpu_hold); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL %s_word_count got %0d required 2", tag, word_count); end
    checks++; if (wrAddr.size() - base !== 2) begin errors++; $display("FAIL %s_writes got %0d required 2", tag, wrAddr.size() - base); end
    for (int i = 0; i < 2 && base + i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== img[i]) begin
        errors++;
        $display("FAIL %s_word%0d got %h@%0d required %h@%0d", tag, i, wrData[base+i], wrAddr[base+i], img[i], i);
      end
    end
  endtask

  task automatic test_zero();
    int base;
    base = wrAddr.size();
    pulseStart();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL restart_flags got done=%0b hold=%0b required done=0 hold=1", done, cpu_hold); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL restart_word_count got %0d required 0", word_count); end
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early got %0b required 0", done); end
    @(negedge clock);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_done got done=%0b hold=%0b required done=1 hold=0", done, cpu_hold); end
    checks++; if (wrAddr.size() !== base) begin errors++; $display("FAIL zero_writes got %0d required 0", wrAddr.size() - base); end
  endtask

  task automatic test_bad_checksum();
    int base, cyc;
    img  = '{32'h01020304};
    base = wrAddr.size();
    pulseStart();
    sendImage(0, 1'b1);
    waitEnd(cyc);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL badck_flags got err=%0b done=%0b required err=1 done=0", error, done); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL badck_cpu_hold got %0b required 1", cpu_hold); end
    checks++;
    if (wrAddr.size() - base !== 1 || wrData[base] !== 32'h01020304 || wrAddr[base] !== 8'd0) begin
      errors++;
      $display("FAIL badck_write got %0d writes required one 01020304@0", wrAddr.size() - base);
    end
  endtask

  task automatic test_length();
    int base, cyc, bad;
    base = wrAddr.size();
    pulseStart();
    sendByte(8'h01, 0);
    sendByte(8'h01, 0);
    @(negedge clock);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL len257_error got %0b required 1", error); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL len257_rx_ready got %0b required 0", rx_ready); end
    checks++; if (wrAddr.size() !== base) begin errors++; $display("FAIL len257_writes got %0d required 0", wrAddr.size() - base); end
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back($urandom);
    pulseStart();
    sendImage(0, 1'b0);
    waitEnd(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len256_done got %0b required 1", done); end
    checks++; if (word_count !== 16'd256) begin errors++; $display("FAIL len256_word_count got %0d required 256", word_count); end
    checks++; if (wrAddr.size() - base !== 256) begin errors++; $display("FAIL len256_writes got %0d required 256", wrAddr.size() - base); end
    checks++; if (wrAddr[wrAddr.size()-1] !== 8'hFF) begin errors++; $display("FAIL len256_last_addr got %h required ff", wrAddr[wrAddr.size()-1]); end
    bad = 0;
    for (int i = 0; i < 256 && base + i < wrAddr.size(); i++)
      if (wrAddr[base+i] !== 8'(i) || wrData[base+i] !== img[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL len256_contents got %0d bad words required 0", bad); end
  endtask

  task automatic test_timeout();
    int base, idle, cyc;
    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    base = wrAddr.size();
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    for (int k = 3; k >= 1; k--) sendByte(8'((img[0] >> (8 * k)) & 32'hFF), 0);
    idle = 0;
    while (!error && idle < 40) begin
      @(negedge clock);
      idle++;
    end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error got %0b required 1", error); end
    checks++; if (idle < 14 || idle > 18) begin errors++; $display("FAIL timeout_cycles got %0d required 14..18", idle); end
    checks++; if (wrAddr.size() !== base || cpu_hold !== 1'b1) begin errors++; $display("FAIL timeout_side got writes=%0d hold=%0b required 0 and 1", wrAddr.size() - base, cpu_hold); end
    pulseStart();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_restart_error got %0b required 0", error); end
    sendImage(0, 1'b0);
    waitEnd(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_reload_done got %0b required 1", done); end
    checks++; if (wrData[wrData.size()-1] !== img[1]) begin errors++; $display("FAIL timeout_reload_word got %h required %h", wrData[wrData.size()-1], img[1]); end
  endtask

  task automatic test_reset_mid();
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back($urandom);
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h04, 0);
    for (int i = 0; i < 2; i++)
      for (int k = 3; k >= 0; k--) sendByte(8'((img[i] >> (8 * k)) & 32'hFF), 0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd1) begin errors++; $display("FAIL write_latency got we=%0b addr=%0d required we=1 addr=1", imem_we, imem_addr); end
    checks++; if (imem_wdata !== img[1]) begin errors++; $display("FAIL write_data got %h required %h", imem_wdata, img[1]); end
    #1 reset = 1'b1;
    #1;
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL midreset_imem_we got %0b required 0", imem_we); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL midreset_rx_ready got %0b required 0", rx_ready); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midreset_flags got hold=%0b done=%0b err=%0b required 1 0 0", cpu_hold, done, error); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL midreset_word_count got %0d required 0", word_count); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (rx_ready !== 1'b0 || imem_we !== 1'b0) begin errors++; $display("FAIL postreset_idle got ready=%0b we=%0b required 0 0", rx_ready, imem_we); end
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_zero();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_basic(12, "gaps");
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
